// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect controller for the decode stage of an IF/ID/EX pipeline.
// A scoreboard tracks load destinations that have not yet written back.
// Decode stalls while either source register it reads is still pending.
// A taken jump or branch from EX flushes the younger stages and redirects the PC.
// A saturating counter records stall and flush cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal operation; load-use / ext hold evaluated per cycle
//   ST_FLUSH | post-redirect flush window; younger stages invalidated
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_instr_valid_in,
    input  logic [4:0]             id_reg1_addr_in,
    input  logic [4:0]             id_reg2_addr_in,
    input  logic [4:0]             id_write_addr_in,
    input  logic                   id_wen_in,
    input  logic                   id_is_load_in,
    input  logic                   ex_jump_flag_in,
    input  logic [31:0]            ex_jump_addr_in,
    input  logic                   wb_wen_in,
    input  logic [4:0]             wb_write_addr_in,
    input  logic                   ext_hold_in,
    output logic                   hold_if_out,
    output logic                   hold_id_out,
    output logic                   flush_id_out,
    output logic                   flush_ex_out,
    output logic                   pc_jump_en_out,
    output logic [31:0]            pc_jump_addr_out,
    output logic                   issue_out,
    output logic [STALL_CNT_W-1:0] stall_cnt_out
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    // The jump cycle is itself the first flush cycle, so the counter only
    // has to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    logic                   state_q, state_d;
    logic [FC_W-1:0]        fcnt_q, fcnt_d;
    logic [31:0]            sb_q, sb_d;
    logic [31:0]            jaddr_q;
    logic [STALL_CNT_W-1:0] scnt_q, scnt_d;
    logic                   hazard;
    logic                   hold;

    // Per-cycle control decision in priority order: jump, flush, load-use, ext hold, issue.
    always_comb begin
        state_d        = state_q;
        fcnt_d         = fcnt_q;
        hold           = 1'b0;
        flush_id_out   = 1'b0;
        flush_ex_out   = 1'b0;
        pc_jump_en_out = 1'b0;
        issue_out      = 1'b0;
        hazard         = id_instr_valid_in &
                         (sb_q[id_reg1_addr_in] | sb_q[id_reg2_addr_in]);
        if (ex_jump_flag_in) begin
            pc_jump_en_out = 1'b1;
            flush_id_out   = 1'b1;
            flush_ex_out   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                fcnt_d  = FC_RELOAD;
            end
        end else if (state_q == ST_FLUSH) begin
            flush_id_out = 1'b1;
            flush_ex_out = 1'b1;
            if (fcnt_q <= FC_W'(1)) begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - FC_W'(1);
            end
        end else if (hazard || ext_hold_in) begin
            hold = 1'b1;
        end else begin
            issue_out = id_instr_valid_in;
        end
    end

    assign hold_if_out      = hold;
    assign hold_id_out      = hold;
    assign pc_jump_addr_out = ex_jump_flag_in ? ex_jump_addr_in : jaddr_q;
    assign stall_cnt_out    = scnt_q;

    // Scoreboard next state: writeback clears, issuing load sets (set wins), x0 never pending.
    always_comb begin
        sb_d = sb_q;
        if (wb_wen_in)
            sb_d[wb_write_addr_in] = 1'b0;
        if (issue_out && id_is_load_in && id_wen_in && (id_write_addr_in != 5'd0))
            sb_d[id_write_addr_in] = 1'b1;
        sb_d[0] = 1'b0;
    end

    // Saturating stall/flush cycle counter.
    always_comb begin
        scnt_d = scnt_q;
        if ((hold || (state_q == ST_FLUSH)) && (scnt_q != {STALL_CNT_W{1'b1}}))
            scnt_d = scnt_q + STALL_CNT_W'(1);
    end

    // State, scoreboard, counters and last redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            sb_q    <= '0;
            jaddr_q <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            sb_q    <= sb_d;
            scnt_q  <= scnt_d;
            if (ex_jump_flag_in)
                jaddr_q <= ex_jump_addr_in;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_instr_valid_in;
    logic [4:0]  id_reg1_addr_in;
    logic [4:0]  id_reg2_addr_in;
    logic [4:0]  id_write_addr_in;
    logic        id_wen_in;
    logic        id_is_load_in;
    logic        ex_jump_flag_in;
    logic [31:0] ex_jump_addr_in;
    logic        wb_wen_in;
    logic [4:0]  wb_write_addr_in;
    logic        ext_hold_in;
    logic        hold_if_out;
    logic        hold_id_out;
    logic        flush_id_out;
    logic        flush_ex_out;
    logic        pc_jump_en_out;
    logic [31:0] pc_jump_addr_out;
    logic        issue_out;
    logic [15:0] stall_cnt_out;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .STALL_CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_instr_valid_in (id_instr_valid_in),
        .id_reg1_addr_in   (id_reg1_addr_in),
        .id_reg2_addr_in   (id_reg2_addr_in),
        .id_write_addr_in  (id_write_addr_in),
        .id_wen_in         (id_wen_in),
        .id_is_load_in     (id_is_load_in),
        .ex_jump_flag_in   (ex_jump_flag_in),
        .ex_jump_addr_in   (ex_jump_addr_in),
        .wb_wen_in         (wb_wen_in),
        .wb_write_addr_in  (wb_write_addr_in),
        .ext_hold_in       (ext_hold_in),
        .hold_if_out       (hold_if_out),
        .hold_id_out       (hold_id_out),
        .flush_id_out      (flush_id_out),
        .flush_ex_out      (flush_ex_out),
        .pc_jump_en_out    (pc_jump_en_out),
        .pc_jump_addr_out  (pc_jump_addr_out),
        .issue_out         (issue_out),
        .stall_cnt_out     (stall_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] wr, input logic wen, input logic ld);
        id_instr_valid_in = v;
        id_reg1_addr_in   = r1;
        id_reg2_addr_in   = r2;
        id_write_addr_in  = wr;
        id_wen_in         = wen;
        id_is_load_in     = ld;
    endtask

    task automatic wb(input logic en, input logic [4:0] a);
        wb_wen_in        = en;
        wb_write_addr_in = a;
    endtask

    task automatic jmp(input logic en, input logic [31:0] a);
        ex_jump_flag_in = en;
        ex_jump_addr_in = a;
    endtask

    // hold, issue, flush bundled as {hold_if, hold_id, issue, flush_id, flush_ex}
    function automatic logic [31:0] ctl();
        return {27'd0, hold_if_out, hold_id_out, issue_out, flush_id_out, flush_ex_out};
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        wb(0, 0);
        jmp(0, 32'h0);
        ext_hold_in = 1'b0;
        #12;
        chk("reset_ctl", ctl(), 32'b00000);
        chk("reset_jen", {31'd0, pc_jump_en_out}, 32'd0);
        chk("reset_jaddr", pc_jump_addr_out, 32'd0);
        chk("reset_scnt", {16'd0, stall_cnt_out}, 32'd0);
        rst = 1'b0;

        // plain issue, no hazards
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1, 5'd1, 5'd2, 5'd3, 1, 0);
            #1;
            chk("basic_issue", ctl(), 32'b00100);
        end

        // LW x5 then reader of x5
        tick(); drive(1, 5'd1, 5'd0, 5'd5, 1, 1); #1;
        chk("lw5_issue", ctl(), 32'b00100);
        tick(); drive(1, 5'd5, 5'd0, 5'd6, 1, 0); #1;
        chk("lu_stall1", ctl(), 32'b11000);
        tick(); #1;
        chk("lu_stall2", ctl(), 32'b11000);
        tick(); wb(1, 5'd5); #1;
        chk("lu_wb_same_cycle", ctl(), 32'b11000);
        tick(); wb(0, 5'd0); #1;
        chk("lu_release", ctl(), 32'b00100);
        chk("scnt_after_lu", {16'd0, stall_cnt_out}, 32'd3);

        // jump during a load-use stall
        tick(); drive(1, 5'd0, 5'd0, 5'd9, 1, 1); #1;
        chk("lw9_issue", ctl(), 32'b00100);
        tick(); drive(1, 5'd0, 5'd9, 5'd4, 1, 0); #1;
        chk("lu9_stall", ctl(), 32'b11000);
        tick(); jmp(1, 32'h0000_0100); #1;
        chk("jump_ctl", ctl(), 32'b00011);
        chk("jump_en", {31'd0, pc_jump_en_out}, 32'd1);
        chk("jump_addr", pc_jump_addr_out, 32'h100);
        tick(); jmp(0, 32'hDEAD_BEEF); drive(0, 0, 0, 0, 0, 0); #1;
        chk("flush_cyc2", ctl(), 32'b00011);
        chk("flush_jen_low", {31'd0, pc_jump_en_out}, 32'd0);
        chk("jaddr_held", pc_jump_addr_out, 32'h100);
        chk("scnt_in_flush", {16'd0, stall_cnt_out}, 32'd4);
        tick(); drive(1, 5'd9, 5'd0, 5'd4, 1, 0); #1;
        chk("run_sb9_kept", ctl(), 32'b11000);
        chk("scnt_after_flush", {16'd0, stall_cnt_out}, 32'd5);
        tick(); wb(1, 5'd9); #1;
        chk("lu9_wb_cycle", ctl(), 32'b11000);
        tick(); wb(0, 5'd0); #1;
        chk("lu9_release", ctl(), 32'b00100);
        chk("scnt_7", {16'd0, stall_cnt_out}, 32'd7);

        // load to x0 never creates a hazard
        tick(); drive(1, 5'd0, 5'd0, 5'd0, 1, 1); #1;
        chk("ld_x0_issue", ctl(), 32'b00100);
        tick(); drive(1, 5'd0, 5'd0, 5'd8, 1, 0); #1;
        chk("x0_reader", ctl(), 32'b00100);

        // same-cycle set and clear of x7: set wins
        tick(); drive(1, 5'd1, 5'd2, 5'd7, 1, 1); wb(1, 5'd7); #1;
        chk("ld7_issue", ctl(), 32'b00100);
        tick(); drive(1, 5'd7, 5'd0, 5'd8, 1, 0); wb(0, 5'd0); #1;
        chk("set_wins", ctl(), 32'b11000);
        tick(); wb(1, 5'd7); #1;
        chk("lu7_wb_cycle", ctl(), 32'b11000);
        tick(); wb(0, 5'd0); #1;
        chk("lu7_release", ctl(), 32'b00100);
        chk("scnt_9", {16'd0, stall_cnt_out}, 32'd9);

        // external hold
        tick(); drive(1, 5'd1, 5'd2, 5'd3, 1, 0); ext_hold_in = 1'b1; #1;
        chk("ext_hold", ctl(), 32'b11000);
        tick(); ext_hold_in = 1'b0; #1;
        chk("ext_release", ctl(), 32'b00100);
        chk("scnt_10", {16'd0, stall_cnt_out}, 32'd10);

        // jump while in FLUSH reloads the window
        tick(); jmp(1, 32'h0000_0100); #1;
        chk("jumpA", ctl(), 32'b00011);
        tick(); jmp(1, 32'h0000_0200); #1;
        chk("jumpB_addr", pc_jump_addr_out, 32'h200);
        chk("jumpB_ctl", ctl(), 32'b00011);
        tick(); jmp(0, 32'h0); #1;
        chk("reload_flush", ctl(), 32'b00011);
        chk("reload_jaddr", pc_jump_addr_out, 32'h200);
        tick(); #1;
        chk("reload_run", ctl(), 32'b00100);
        chk("scnt_12", {16'd0, stall_cnt_out}, 32'd12);

        // async reset in the middle of a flush
        tick(); jmp(1, 32'h0000_0300); #1;
        tick(); jmp(0, 32'h0); drive(0, 0, 0, 0, 0, 0); #1;
        chk("pre_rst_flush", ctl(), 32'b00011);
        rst = 1'b1; #1;
        chk("rst_mid_flush_ctl", ctl(), 32'b00000);
        chk("rst_mid_flush_jen", {31'd0, pc_jump_en_out}, 32'd0);
        chk("rst_mid_flush_jaddr", pc_jump_addr_out, 32'd0);
        chk("rst_mid_flush_scnt", {16'd0, stall_cnt_out}, 32'd0);
        rst = 1'b0;

        // counter saturation under a long hold
        ext_hold_in = 1'b1;
        repeat (10) tick();
        chk("scnt_count10", {16'd0, stall_cnt_out}, 32'd10);
        repeat ((1 << 16) + 3 - 10) tick();
        chk("scnt_saturate", {16'd0, stall_cnt_out}, 32'h0000_FFFF);
        chk("sat_hold", ctl(), 32'b11000);
        ext_hold_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
